mem_operand_stream: RTL and testbench

- Parametrised operand memory for the Montgomery-product datapath. It is the next generation of the fixed read-only zero/constant word store.
- Adds a random-access write port, a burst read sequencer (base address + length) and a valid/ready output stream with backpressure.
- Keeps the registered-address / registered-data memory timing, so the array still maps to block RAM.
- Sits between the operand loader and the monpro word-serial multiplier.

---
 rtl/mem_operand_stream.sv | 217 +++++++++++++++++++++
 tb/tb_mem_operand_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_operand_stream.sv
// Operand memory: random-access write port, burst read sequencer and valid/ready stream.
// Define MEM_ZERO_INIT_EN to zero-fill the array after every reset (CLEAR state).
module mem_operand_stream #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_err,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;
  localparam int unsigned BPW   = $clog2(BUF_DEPTH);
  localparam int unsigned CW    = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OW    = CW + 1;

`ifdef MEM_ZERO_INIT_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_CLEAR} state_e;
  localparam state_e RST_STATE = S_CLEAR;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_e;
  localparam state_e RST_STATE = S_IDLE;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] iss_ptr_q, iss_ptr_d;
  logic [LW-1:0]         iss_cnt_q, iss_cnt_d;
  logic [LW-1:0]         dlv_cnt_q, dlv_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  p1_vld_q, p1_vld_d;
  logic                  p2_vld_q, p2_vld_d;
  logic [WIDTH-1:0]      rd_data_q;
  logic [WIDTH-1:0]      buf_mem_q [BUF_DEPTH];
  logic [WIDTH-1:0]      buf_mem_d [BUF_DEPTH];
  logic [BPW-1:0]        buf_wp_q, buf_wp_d;
  logic [BPW-1:0]        buf_rp_q, buf_rp_d;
  logic [CW-1:0]         buf_cnt_q, buf_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;
`ifdef MEM_ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`endif

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  issue;
  logic                  hs;
  logic [OW-1:0]         occ;

  function automatic logic [BPW-1:0] buf_inc(input logic [BPW-1:0] p);
    return (p == BPW'(BUF_DEPTH - 1)) ? '0 : p + BPW'(1);
  endfunction

  // Next-state, issue credit and skid-buffer bookkeeping
  always_comb begin
    state_d    = state_q;
    iss_ptr_d  = iss_ptr_q;
    iss_cnt_d  = iss_cnt_q;
    dlv_cnt_d  = dlv_cnt_q;
    rd_addr_d  = rd_addr_q;
    buf_mem_d  = buf_mem_q;
    buf_wp_d   = buf_wp_q;
    buf_rp_d   = buf_rp_q;
    buf_cnt_d  = buf_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    done_d     = 1'b0;
    issue      = 1'b0;
    wr_err_d   = wr_en && (state_q != S_IDLE);
    hs         = out_valid_q && out_ready;
    occ        = OW'(buf_cnt_q) + OW'(p1_vld_q) + OW'(p2_vld_q);
`ifdef MEM_ZERO_INIT_EN
    clr_addr_d = clr_addr_q;
`endif

    if (hs) dlv_cnt_d = dlv_cnt_q - LW'(1);

    case (state_q)
      S_IDLE: begin
        mem_we = wr_en;
        if (rd_start) begin
          if (rd_len != '0) begin
            state_d   = S_STREAM;
            iss_ptr_d = rd_base;
            iss_cnt_d = rd_len;
            dlv_cnt_d = rd_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        // Reads in flight count against buffer space so nothing is ever dropped
        if ((iss_cnt_q != '0) && (occ < OW'(BUF_DEPTH))) begin
          issue     = 1'b1;
          rd_addr_d = iss_ptr_q;
          iss_ptr_d = iss_ptr_q + ADDR_WIDTH'(1);
          iss_cnt_d = iss_cnt_q - LW'(1);
          if (iss_cnt_q == LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dlv_cnt_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef MEM_ZERO_INIT_EN
      S_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    p1_vld_d = issue;
    p2_vld_d = p1_vld_q;

    if (p2_vld_q) begin
      buf_mem_d[buf_wp_q] = rd_data_q;
      buf_wp_d            = buf_inc(buf_wp_q);
    end
    if (hs) buf_rp_d = buf_inc(buf_rp_q);
    buf_cnt_d = buf_cnt_q + CW'(p2_vld_q) - CW'(hs);

    out_valid_d = (buf_cnt_d != '0);
    out_last_d  = out_valid_d && (dlv_cnt_d == LW'(1));
    out_data_d  = buf_mem_d[buf_rp_d];
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      iss_ptr_q   <= '0;
      iss_cnt_q   <= '0;
      dlv_cnt_q   <= '0;
      rd_addr_q   <= '0;
      p1_vld_q    <= 1'b0;
      p2_vld_q    <= 1'b0;
      buf_mem_q   <= '{default: '0};
      buf_wp_q    <= '0;
      buf_rp_q    <= '0;
      buf_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
`ifdef MEM_ZERO_INIT_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      iss_ptr_q   <= iss_ptr_d;
      iss_cnt_q   <= iss_cnt_d;
      dlv_cnt_q   <= dlv_cnt_d;
      rd_addr_q   <= rd_addr_d;
      p1_vld_q    <= p1_vld_d;
      p2_vld_q    <= p2_vld_d;
      buf_mem_q   <= buf_mem_d;
      buf_wp_q    <= buf_wp_d;
      buf_rp_q    <= buf_rp_d;
      buf_cnt_q   <= buf_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
`ifdef MEM_ZERO_INIT_EN
      clr_addr_q  <= clr_addr_d;
`endif
    end
  end

  // Array and its data register stay reset-free so they map onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data_q <= mem[rd_addr_q];
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_mem_operand_stream.sv
// Directed plus randomized bench for mem_operand_stream against an array/queue reference model.
module tb_mem_operand_stream;
  localparam int W  = 32;
  localparam int AW = 7;
  localparam int LW = AW + 1;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_err;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [LW-1:0] rd_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [W-1:0] ref_mem [D];
  int checks = 0;
  int errors = 0;

  mem_operand_stream #(.WIDTH(W), .ADDR_WIDTH(AW), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic wr(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    ref_mem[a % D] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_wrerr"}, wr_err, 0);
  endtask

  task automatic post_reset();
`ifdef MEM_ZERO_INIT_EN
    int n;
    step();
    chk("clear_busy", busy, 1);
    n = 1;
    while (busy && n < 1000) begin
      if (n == 5) begin
        wr_en = 1'b1; wr_addr = AW'(9); wr_data = '1;
        rd_start = 1'b1; rd_base = '0; rd_len = LW'(1);
      end
      if (n == 6) begin
        wr_en = 1'b0; rd_start = 1'b0;
        chk("clear_wr_err", wr_err, 1);
      end
      step();
      n++;
    end
    chk("clear_cycles", n, 128);
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
`else
    step();
    chk("busy_low_after_release", busy, 0);
`endif
  endtask

  // One burst: drives backpressure per mode and checks order, hold, last and done against the model
  task automatic burst(input int base, input int len, input int mode, input bit inject);
    int idx;
    int cyc;
    bit first;
    bit stalled;
    logic [W-1:0] held;
    logic [W-1:0] expd;
    idx = 0; cyc = 0; first = 1'b0; stalled = 1'b0; held = '0;
    rd_base = AW'(base); rd_len = LW'(len); rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (idx < len && cyc < 2000) begin
      if (inject) begin
        if (cyc == 1) begin
          wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'hDEAD_BEEF;
          rd_start = 1'b1; rd_base = AW'(base + 5); rd_len = LW'(2);
        end else if (cyc == 2) begin
          wr_en = 1'b0; rd_start = 1'b0;
          chk("wr_err_pulse", wr_err, 1);
        end else if (cyc == 3) begin
          chk("wr_err_one_cycle", wr_err, 0);
        end
      end
      if (out_valid && !first) begin
        first = 1'b1;
        chk("first_valid_cycle", cyc, 3);
      end
      if (stalled) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, held);
      end
      out_ready = ready_pat(mode, cyc);
      if (out_valid) begin
        if (out_ready) begin
          expd = ref_mem[(base + idx) % D];
          chk("data", out_data, expd);
          chk("last", out_last, (idx == len - 1));
          idx++;
          stalled = 1'b0;
        end else begin
          held = out_data;
          stalled = 1'b1;
        end
      end
      step();
      cyc++;
    end
    chk("burst_completed", idx, len);
    if (mode == 0) chk("burst_cycles", cyc, len + 3);
    chk("done_pulse", done, 1);
    chk("valid_low_after", out_valid, 0);
    chk("busy_low_after", busy, 0);
    out_ready = 1'b0;
    step();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int hs;
    int n;
    int nw;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    post_reset();

`ifdef MEM_ZERO_INIT_EN
    burst(0, 128, 0, 1'b0);
`endif

    for (int i = 0; i < D; i++) wr(i, $urandom);
    chk("wr_err_idle", wr_err, 0);

    for (int i = 0; i < 8; i++) wr(i, 32'h1000_0000 + W'(i));
    burst(0, 8, 0, 1'b0);

    wr(126, 32'hA); wr(127, 32'hB); wr(0, 32'hC);
    burst(126, 3, 0, 1'b0);

    burst(40, 8, 1, 1'b0);

    burst(0, 8, 1, 1'b1);
    burst(3, 1, 0, 1'b0);

    rd_base = AW'(10); rd_len = '0; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_valid", out_valid, 0);
    step();
    chk("len0_done_clear", done, 0);
    chk("len0_valid_stays_low", out_valid, 0);
    chk("len0_busy", busy, 0);

    // Reset in the middle of a burst after three words
    rd_base = AW'(20); rd_len = LW'(8); rd_start = 1'b1; out_ready = 1'b1;
    step();
    rd_start = 1'b0;
    hs = 0; n = 0;
    while (hs < 3 && n < 100) begin
      if (out_valid && out_ready) hs++;
      step();
      n++;
    end
    chk("midreset_progress", hs, 3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    out_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    post_reset();
    burst(20, 8, 0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(0, 4);
      for (int j = 0; j < nw; j++) wr($urandom_range(0, D - 1), $urandom);
      burst($urandom_range(0, D - 1), $urandom_range(1, 24), 2, 1'b0);
    end
    burst(5, 128, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
